// File: rtl/decoder_pkg.sv
// Shared decoder definitions: default geometry and a one-hot/illegal
// decode function usable by any decoder up to DEC_MAX_IN_W input bits.
package decoder_pkg;

  localparam int DEC_IN_W     = 4;
  localparam int DEC_NUM_OUT  = 13;
  localparam int DEC_CNT_W    = 8;

  // Widest code the shared function handles; result is sized for it.
  localparam int DEC_MAX_IN_W = 8;
  localparam int DEC_MAX_OUT  = 2 ** DEC_MAX_IN_W;

  // Returns {illegal, onehot[DEC_MAX_OUT-1:0]}. Callers slice the low
  // num_out bits; the top bit flags a code outside 0..num_out-1.
  function automatic logic [DEC_MAX_OUT:0] dec_onehot(
    input logic [DEC_MAX_IN_W-1:0] code,
    input int unsigned             num_out
  );
    logic [DEC_MAX_OUT:0] res;
    res = '0;
    if ({24'd0, code} < num_out) begin
      res[{1'b0, code}] = 1'b1;
    end else begin
      res[DEC_MAX_OUT] = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/opcode_decoder_pipe_if.sv
// Code-in / one-hot-out handshake bundle for opcode_decoder_pipe.
// slave = decoder view, master = surrounding fetch/execute view.
interface opcode_decoder_pipe_if
  import decoder_pkg::*;
#(
  parameter int IN_W    = DEC_IN_W,
  parameter int NUM_OUT = DEC_NUM_OUT
) ();

  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_code;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_OUT-1:0] out_onehot;
  logic               out_illegal;

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_onehot, out_illegal
  );

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_onehot, out_illegal
  );

endinterface

// File: rtl/opcode_onehot_dec.sv
// Purely combinational binary -> one-hot decoder with illegal flag.
module opcode_onehot_dec
  import decoder_pkg::*;
#(
  parameter int IN_W    = DEC_IN_W,
  parameter int NUM_OUT = DEC_NUM_OUT
) (
  input  logic [IN_W-1:0]    in_code,
  output logic [NUM_OUT-1:0] onehot,
  output logic               illegal
);

  logic [DEC_MAX_OUT:0] dec_full;

  assign dec_full = dec_onehot(DEC_MAX_IN_W'(in_code), NUM_OUT);
  assign illegal  = dec_full[DEC_MAX_OUT];

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_bit
    assign onehot[gi] = dec_full[gi];
  end

  // Bits above NUM_OUT are always zero for this geometry.
  if (NUM_OUT < DEC_MAX_OUT) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^dec_full[DEC_MAX_OUT-1:NUM_OUT];
  end

endmodule

// File: rtl/opcode_decoder_pipe.sv
// Registered opcode decoder: one accepted code per cycle becomes a held
// one-hot result word, with illegal-code flag and saturating counter.
// Optional feature macro: OPCODE_DECODER_CNT_EN (builds the counter).
module opcode_decoder_pipe
  import decoder_pkg::*;
#(
  parameter int IN_W    = DEC_IN_W,
  parameter int NUM_OUT = DEC_NUM_OUT,
  parameter int CNT_W   = DEC_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  opcode_decoder_pipe_if.slave  bus,
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      illegal_cnt
);

  if (NUM_OUT > 2 ** IN_W) begin : g_chk_range
    $error("NUM_OUT exceeds 2**IN_W");
  end
  if (NUM_OUT < 1) begin : g_chk_min
    $error("NUM_OUT must be at least 1");
  end
  if (IN_W > DEC_MAX_IN_W) begin : g_chk_w
    $error("IN_W wider than the shared decode function supports");
  end

  logic               out_valid_reg;
  logic [NUM_OUT-1:0] onehot_reg;
  logic               illegal_reg;
  logic [NUM_OUT-1:0] dec_onehot_w;
  logic               dec_illegal;
  logic               in_ready;
  logic               accept;

  opcode_onehot_dec #(
    .IN_W    (IN_W),
    .NUM_OUT (NUM_OUT)
  ) u_dec (
    .in_code (bus.in_code),
    .onehot  (dec_onehot_w),
    .illegal (dec_illegal)
  );

  // Single stage: free when empty or when the held result leaves now.
  assign in_ready = !out_valid_reg || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // Output register: load on accept, drop valid on a bare completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      onehot_reg    <= '0;
      illegal_reg   <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      onehot_reg    <= dec_onehot_w;
      illegal_reg   <= dec_illegal;
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_onehot  = onehot_reg;
  assign bus.out_illegal = illegal_reg;

`ifdef OPCODE_DECODER_CNT_EN
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Clear first, then count the accepted illegal code, saturating.
  always_comb begin
    cnt_next = clr_cnt ? '0 : cnt_reg;
    if (accept && dec_illegal && (cnt_next != {CNT_W{1'b1}})) begin
      cnt_next = cnt_next + CNT_W'(1);
    end
  end

  // Counter register, updated on the same edge as the result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign illegal_cnt = cnt_reg;
`else
  logic unused_clr;
  assign unused_clr  = clr_cnt;
  assign illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_opcode_decoder_pipe.sv
// Scoreboard bench for opcode_decoder_pipe (CNT_W=2 so saturation is
// reachable). Works with or without OPCODE_DECODER_CNT_EN defined.
module tb_opcode_decoder_pipe;

  localparam int IN_W    = 4;
  localparam int NUM_OUT = 13;
  localparam int CNT_W   = 2;
`ifdef OPCODE_DECODER_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct packed {
    logic [NUM_OUT-1:0] onehot;
    logic               illegal;
    logic [CNT_W-1:0]   cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] illegal_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  int   model_cnt = 0;

  opcode_decoder_pipe_if #(.IN_W(IN_W), .NUM_OUT(NUM_OUT)) bus ();

  opcode_decoder_pipe #(
    .IN_W    (IN_W),
    .NUM_OUT (NUM_OUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .clr_cnt     (clr_cnt),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int v);
    return CNT_ON ? 32'(v) : 32'd0;
  endfunction

  // Monitor: on the falling edge compare the leaving result, then log
  // the code about to be accepted on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        check_eq("onehot_excl", 32'($countones(bus.out_onehot) <= 1), 32'd1);
        if (bus.out_ready) begin
          if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq("sb_onehot", 32'(bus.out_onehot), 32'(e.onehot));
            check_eq("sb_illegal", 32'(bus.out_illegal), 32'(e.illegal));
            check_eq("sb_cnt", 32'(illegal_cnt), 32'(e.cnt));
          end
        end
      end
      if (clr_cnt) model_cnt = 0;
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        int   code;
        code = int'(bus.in_code);
        e.illegal = (code >= NUM_OUT);
        e.onehot  = '0;
        if (code < NUM_OUT) e.onehot[code] = 1'b1;
        if (e.illegal && model_cnt < (2 ** CNT_W - 1)) model_cnt++;
        e.cnt = CNT_ON ? CNT_W'(model_cnt) : '0;
        sb_q.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sat_exp[5];
    sat_exp = '{1, 2, 3, 3, 3};
    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_onehot", 32'(bus.out_onehot), 32'd0);
    check_eq("rst_illegal", 32'(bus.out_illegal), 32'd0);
    check_eq("rst_cnt", 32'(illegal_cnt), 32'd0);
    check_eq("rst_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    // Back-to-back sweep of all codes
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (i > 0) check_eq("sweep_nobubble", 32'(bus.out_valid), 32'd1);
      check_eq("sweep_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_code  = IN_W'(i);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_eq("sweep_last_valid", 32'(bus.out_valid), 32'd1);
    check_eq("sweep_last_illegal", 32'(bus.out_illegal), 32'd1);
    check_eq("sweep_cnt", 32'(illegal_cnt), exp_cnt(3));

    // Back-pressure: hold code 5 while code 7 waits
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_code  = 4'd5;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_code   = 4'd7;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check_eq("bp_hold_onehot", 32'(bus.out_onehot), 32'h0020);
      check_eq("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_eq("bp_next_onehot", 32'(bus.out_onehot), 32'h0080);
    check_eq("bp_next_valid", 32'(bus.out_valid), 32'd1);

    // Clear alone, then saturation with 5 illegal codes
    @(posedge clk);
    #1;
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    check_eq("clr_alone", 32'(illegal_cnt), 32'd0);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_code  = IN_W'(13 + (k % 3));
      @(posedge clk);
      #1;
      check_eq("sat_cnt", 32'(illegal_cnt), exp_cnt(sat_exp[k]));
    end
    bus.in_valid = 1'b0;

    // Clear colliding with an illegal accept at count 2
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_code  = 4'd13;
    repeat (2) @(posedge clk);
    #1;
    check_eq("coll_pre_cnt", 32'(illegal_cnt), exp_cnt(2));
    clr_cnt     = 1'b1;
    bus.in_code = 4'd14;
    @(posedge clk);
    #1;
    clr_cnt      = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("coll_cnt", 32'(illegal_cnt), exp_cnt(1));
    check_eq("coll_illegal", 32'(bus.out_illegal), 32'd1);

    // Async reset while a result is held
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_code   = 4'd3;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_eq("ar_pre_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_valid", 32'(bus.out_valid), 32'd0);
    check_eq("ar_onehot", 32'(bus.out_onehot), 32'd0);
    check_eq("ar_cnt", 32'(illegal_cnt), 32'd0);
    check_eq("ar_ready", 32'(bus.in_ready), 32'd1);
    sb_q.delete();
    model_cnt = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // Code 15: illegal flag always, counter only when built
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_code  = 4'd15;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_eq("c15_illegal", 32'(bus.out_illegal), 32'd1);
    check_eq("c15_onehot", 32'(bus.out_onehot), 32'd0);
    check_eq("c15_cnt", 32'(illegal_cnt), exp_cnt(1));

    // Drain scoreboard with a bounded wait
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
    #1;
    check_eq("drain", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
